// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   N_REQ       : number of requesters, fixed at 4 to match the 4:1 mux
//   SEL_W       : width of the mux select / owner index
//   onehot()    : converts an owner index into a one-hot grant vector
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder.
//   req   : request vector, bit i = requester i
//   ptr   : highest-priority index; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   idx   : first requesting index in search order (ptr when nothing is set)
//   found : at least one request is set
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand [N_REQ];
  logic [N_REQ-1:0] hit;

  // cand[k] is the requester examined at search position k; the SEL_W-bit
  // addition wraps naturally modulo 4.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign cand[gi] = ptr + SEL_W'(gi);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Walk from the lowest priority position up so the earliest hit wins.
  always_comb begin
    idx   = ptr;
    found = |hit;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select pins of a 4:1 mux.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   req   : request vector, bit i asks for source xi on the mux output
//   grant : registered one-hot grant, 0000 when idle
//   c0/c1 : mux select, source index = {c1,c0}; only changes when a new
//           non-zero grant is issued, so the mux is stable for a whole tenure
//   busy  : high while any grant is active
// Each tenure lasts at most MAX_HOLD cycles; on release the pointer moves
// past the owner and a new owner is picked in the same edge (no bubble).
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             c0,
  output logic             c1,
  output logic             busy
);

  arb_state_t       state_reg, state_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [SEL_W-1:0] owner_reg, owner_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic             busy_reg, busy_next;

  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;

  // In GRANT the only time the picker result is used is on release, where
  // the search must start just past the current owner.
  assign pick_ptr = (state_reg == GRANT) ? (owner_reg + SEL_W'(1)) : ptr_reg;

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    busy_next  = busy_reg;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          owner_next = pick_idx;
          grant_next = onehot(pick_idx);
          busy_next  = 1'b1;
          cnt_next   = CNT_W'(1);
          state_next = GRANT;
        end
      end

      GRANT: begin
        if (req[owner_reg] && (cnt_reg < CNT_W'(MAX_HOLD))) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          ptr_next = owner_reg + SEL_W'(1);
          if (pick_found) begin
            owner_next = pick_idx;
            grant_next = onehot(pick_idx);
            cnt_next   = CNT_W'(1);
          end else begin
            // owner_reg is left alone so c1/c0 hold their last value.
            grant_next = '0;
            busy_next  = 1'b0;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
      grant_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      busy_reg  <= busy_next;
    end
  end

  // The owner register doubles as the mux select.
  assign grant = grant_reg;
  assign busy  = busy_reg;
  assign c0    = owner_reg[0];
  assign c1    = owner_reg[1];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares after every rising edge.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       c0;
  logic       c1;
  logic       busy;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    int         tid;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   tid;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .c0    (c0),
    .c1    (c1),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp4(input string name, input logic [3:0] act, input logic [3:0] want, input int t);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s test%0d t=%0t got=%b want=%b", name, t, $time, act, want);
    end
  endtask

  // Drive req ahead of the next edge and record what must appear after it.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input logic b);
    exp_t e;
    @(negedge clk);
    req = r;
    e.grant = g;
    e.sel   = s;
    e.busy  = b;
    e.tid   = tid;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one transaction per rising edge while expectations are queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp4("grant", grant, e.grant, e.tid);
        cmp4("sel", {2'b00, c1, c0}, {2'b00, e.sel}, e.tid);
        cmp4("busy", {3'b000, busy}, {3'b000, e.busy}, e.tid);
        $display("test%0d t=%0t req=%b grant=%b sel=%b%b busy=%b", e.tid, $time, req, grant, c1, c0, busy);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    tid = 0;
    checks = 0;
    errors = 0;

    // Reset held with no requests.
    tid = 1;
    repeat (5) step(4'b0000, 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000, 4'b0000, 2'b00, 1'b0);

    // Single short request, then release; select holds at 10.
    tid = 2;
    repeat (3) step(4'b0100, 4'b0100, 2'b10, 1'b1);
    step(4'b0000, 4'b0000, 2'b10, 1'b0);
    step(4'b0000, 4'b0000, 2'b10, 1'b0);

    // Restart from ptr=0, all requesting: 8-cycle tenures in rotation.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tid = 3;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      o = 2'((i / 8) % 4);
      step(4'b1111, 4'b0001 << o, o, 1'b1);
    end
    // Owner 0 finished its tenure; nothing requesting -> idle, select holds.
    step(4'b0000, 4'b0000, 2'b00, 1'b0);

    // ptr=1: owner 1, then it drops and 3 takes over without a bubble.
    tid = 4;
    step(4'b1010, 4'b0010, 2'b01, 1'b1);
    step(4'b1010, 4'b0010, 2'b01, 1'b1);
    step(4'b1000, 4'b1000, 2'b11, 1'b1);
    step(4'b0000, 4'b0000, 2'b11, 1'b0);

    // ptr=0: sole requester is re-granted at expiry with no gap.
    tid = 5;
    repeat (20) step(4'b0001, 4'b0001, 2'b00, 1'b1);

    // Owner 0 drops, 2 wins; then async reset between edges.
    tid = 6;
    step(4'b0100, 4'b0100, 2'b10, 1'b1);
    #2;
    req = 4'b0000;
    rst = 1'b1;
    #1;
    cmp4("async_grant", grant, 4'b0000, tid);
    cmp4("async_sel", {2'b00, c1, c0}, 4'b0000, tid);
    cmp4("async_busy", {3'b000, busy}, 4'b0000, tid);
    $display("test%0d t=%0t async reset grant=%b sel=%b%b busy=%b", tid, $time, grant, c1, c0, busy);
    #1;
    rst = 1'b0;
    step(4'b1010, 4'b0010, 2'b01, 1'b1);
    step(4'b1010, 4'b0010, 2'b01, 1'b1);
    step(4'b0000, 4'b0000, 2'b01, 1'b0);

    // Bounded drain of the scoreboard.
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
